// File: rtl/numpad_entry.sv
// numpad_entry: turns decoded keyboard make events into a 4-digit
// right-justified decimal entry buffer that drives the seven-segment digits.
// Supports backspace, clear and commit. Commit runs a fixed four-cycle
// BCD-to-binary conversion, then pulses value_valid for one cycle.

module numpad_entry #(
  parameter logic [8:0] KEY_BKSP  = 9'h066,
  parameter logic [8:0] KEY_ENTER = 9'h05A,
  parameter logic [8:0] KEY_ESC   = 9'h076,
  parameter logic [3:0] BLANK     = 4'd15,
  parameter logic [3:0] DASH      = 4'd10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic [3:0]   digit_3,
  output logic [3:0]   digit_2,
  output logic [3:0]   digit_1,
  output logic [3:0]   digit_0,
  output logic [13:0]  value,
  output logic         value_valid,
  output logic         busy,
  output logic [2:0]   count
);

  // The keypad Enter key carries the extended prefix.
  localparam logic [8:0] KEY_KP_ENTER = 9'h15A;

  typedef enum logic [2:0] {
    EMPTY,
    ENTRY,
    FULL,
    CONVERT,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  d3, d2, d1, d0;
  logic [13:0] acc;
  logic [1:0]  step;

  logic        make;
  logic        is_digit;
  logic [3:0]  key_val;
  logic        is_bksp;
  logic        is_esc;
  logic        is_enter;
  logic [3:0]  conv_sel;
  logic [3:0]  conv_digit;
  logic [17:0] conv_sum;
  logic [13:0] acc_next;

  // Qualify the incoming event and classify the key.
  always_comb begin
    make     = key_valid & en & key_down[last_change];
    is_digit = 1'b1;
    key_val  = 4'd0;
    case (last_change)
      9'h070:  key_val = 4'd0;
      9'h069:  key_val = 4'd1;
      9'h072:  key_val = 4'd2;
      9'h07A:  key_val = 4'd3;
      9'h06B:  key_val = 4'd4;
      9'h073:  key_val = 4'd5;
      9'h074:  key_val = 4'd6;
      9'h06C:  key_val = 4'd7;
      9'h075:  key_val = 4'd8;
      9'h07D:  key_val = 4'd9;
      default: is_digit = 1'b0;
    endcase
    is_bksp  = (last_change == KEY_BKSP);
    is_esc   = (last_change == KEY_ESC);
    is_enter = (last_change == KEY_ENTER) || (last_change == KEY_KP_ENTER);
  end

  // One Horner step per cycle, most significant digit first; blanks count as 0.
  always_comb begin
    case (step)
      2'd0:    conv_sel = d3;
      2'd1:    conv_sel = d2;
      2'd2:    conv_sel = d1;
      default: conv_sel = d0;
    endcase
    conv_digit = (conv_sel == BLANK) ? 4'd0 : conv_sel;
    conv_sum   = ({4'd0, acc} * 18'd10) + {14'd0, conv_digit};
    acc_next   = conv_sum[13:0];
  end

  // Entry buffer, conversion sequencer and committed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      d3          <= BLANK;
      d2          <= BLANK;
      d1          <= BLANK;
      d0          <= BLANK;
      count       <= 3'd0;
      acc         <= 14'd0;
      step        <= 2'd0;
      value       <= 14'd0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      case (state)
        EMPTY: begin
          if (make && is_digit) begin
            d0    <= key_val;
            count <= 3'd1;
            state <= ENTRY;
          end
        end
        ENTRY, FULL: begin
          if (make) begin
            if (is_digit) begin
              if (state == ENTRY) begin
                d3    <= d2;
                d2    <= d1;
                d1    <= d0;
                d0    <= key_val;
                count <= count + 3'd1;
                state <= (count == 3'd3) ? FULL : ENTRY;
              end
            end else if (is_bksp) begin
              d0    <= d1;
              d1    <= d2;
              d2    <= d3;
              d3    <= BLANK;
              count <= count - 3'd1;
              state <= (count == 3'd1) ? EMPTY : ENTRY;
            end else if (is_esc) begin
              d3    <= BLANK;
              d2    <= BLANK;
              d1    <= BLANK;
              d0    <= BLANK;
              count <= 3'd0;
              state <= EMPTY;
            end else if (is_enter) begin
              acc   <= 14'd0;
              step  <= 2'd0;
              state <= CONVERT;
            end
          end
        end
        CONVERT: begin
          acc  <= acc_next;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          value       <= acc;
          value_valid <= 1'b1;
          d3          <= BLANK;
          d2          <= BLANK;
          d1          <= BLANK;
          d0          <= BLANK;
          count       <= 3'd0;
          state       <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign busy    = (state == CONVERT) || (state == DONE);
  assign digit_3 = (state == EMPTY) ? DASH : d3;
  assign digit_2 = (state == EMPTY) ? DASH : d2;
  assign digit_1 = (state == EMPTY) ? DASH : d1;
  assign digit_0 = (state == EMPTY) ? DASH : d0;

endmodule

// File: doc/numpad_entry.md
Name: numpad_entry

Overview:
- Sits directly downstream of KeyboardDecoder and directly upstream of seven_segment.
- Consumes decoded keyboard events, filters for numeric-keypad make codes, and maintains a 4-digit right-justified entry buffer. The buffer supports backspace, clear and commit.
- Drives the four seven_segment digit inputs.
- On commit, converts the BCD buffer to binary over a fixed multi-cycle sequence and presents the result with a one-cycle valid pulse.

Parameters:
KEY_BKSP, 9'h066, backspace code (last_change format {extend, code})
KEY_ENTER, 9'h05A, main Enter code; keypad Enter 9'h15A also accepted (fixed, not a parameter)
KEY_ESC, 9'h076, clear code
BLANK, 4'd15, digit code rendered as no light
DASH, 4'd10, digit code rendered as '-'

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  key acceptance enable; low = all key events ignored, state held
key_valid  in  1  one-cycle event strobe from KeyboardDecoder
last_change  in  9  {extend, scan code} of the event
key_down  in  512  key state vector from KeyboardDecoder
digit_3  out  4  leftmost display digit
digit_2  out  4  display digit
digit_1  out  4  display digit
digit_0  out  4  rightmost display digit
value  out  14  last committed binary value, 0..9999
value_valid  out  1  one-cycle pulse when value updates
busy  out  1  high during CONVERT and DONE
count  out  3  number of entered digits, 0..4

Behaviour:
- Make event: key_valid==1 && key_down[last_change]==1 && en==1. Break events (key_down bit 0) are ignored.
- Digit keys: 9'h070, 069, 072, 07A, 06B, 073, 074, 06C, 075, 07D map to values 0..9. All other codes are ignored.
- Registers: buffer d3..d0 (4 bits each), count, state, acc (14 bits), step (2 bits), value, value_valid.
- Reset values: d3..d0=BLANK, count=0, state=EMPTY, acc=0, value=0, value_valid=0.
- States and transitions:
  - EMPTY: count==0.
    - Digit -> shift in, count=1, ENTRY.
    - Backspace, Esc, Enter -> no effect.
  - ENTRY: count 1..3.
    - Digit -> shift left (d3<=d2, d2<=d1, d1<=d0, d0<=key), count+1; goes to FULL when count reaches 4.
    - Backspace -> shift right (d0<=d1, d1<=d2, d2<=d3, d3<=BLANK), count-1; goes to EMPTY at 0.
    - Esc -> all digits BLANK, count=0, EMPTY.
    - Enter -> acc=0, step=0, CONVERT.
  - FULL: count==4.
    - Digit -> ignored; buffer unchanged.
    - Backspace, Esc, Enter -> as in ENTRY.
  - CONVERT:
    - Each cycle, acc <= acc*10 + (d[3-step]==BLANK ? 0 : d[3-step]); step+1.
    - After step 3, goes to DONE. Always exactly 4 cycles.
    - All key events are ignored and dropped, not queued.
  - DONE (1 cycle): value<=acc, value_valid<=1, buffer cleared to BLANK, count=0, EMPTY.
- Latency: buffer and count update on the same edge that samples the make event. If Enter is sampled at edge E0, CONVERT runs E1..E4, DONE at E5, and value/value_valid are visible after E5. value_valid is high for exactly one cycle.
- acc width: 14 bits is sufficient because max 9999 < 16384; intermediate acc*10 is computed at 18 bits and truncated.
- Display:
  - State EMPTY: digit_3..0 = DASH.
  - Otherwise: digit_n = d_n, so unfilled positions show BLANK.
  - Outputs are combinational from registers.
- busy: combinational, (state==CONVERT || state==DONE).
- en low: key events ignored in every state. A CONVERT already in progress still completes.
- Asynchronous rst mid-CONVERT: aborts immediately to reset values; no value_valid pulse is produced.
- value holds its last committed result until the next commit or reset.

Test Plan:
- Reset, then press 1, 2, 3 (make+break each) -> digit_3..0 = 15, 1, 2, 3; count=3. Immediately after reset, display = 10, 10, 10, 10.
- Enter 9, 8, 7, 6, 5 -> buffer 9, 8, 7, 6 (5 ignored), count=4. Enter at E0 -> busy during E1..E5, value=9876, value_valid pulse after E5, display back to dashes.
- Enter 4, 2, then Backspace -> 15, 15, 15, 4, count=1. Backspace again -> dashes, count=0. Backspace in EMPTY -> no change.
- Enter 0, 7, then keypad Enter (9'h15A) -> value=7. Then Enter in EMPTY -> no pulse; value stays 7.
- With en=0, press 5 -> no change. Entry 3, 1, Esc -> dashes. Break-only event for digit 6 -> no change. Digit pressed during CONVERT -> dropped; committed value unaffected.
- Enter 5, 5, Enter; assert rst at E2 of CONVERT -> all outputs return to reset values; no value_valid pulse occurs.
